// File: rtl/mpdmac_pkg.sv
// Shared definitions for the mirror-padding DMA configuration block: register
// offsets, identification value, legal matrix-width range and the STATUS layout.
package mpdmac_pkg;

    localparam logic [31:0] VERSION   = 32'h0001_2024;
    localparam logic [5:0]  MIN_WIDTH = 6'd2;   // engine mirrors from index width-2
    localparam logic [5:0]  MAX_WIDTH = 6'd14;  // engine burst length width+1 must fit 4 bits

    localparam logic [11:0] OFF_VERSION   = 12'h000;
    localparam logic [11:0] OFF_SRC_ADDR  = 12'h100;
    localparam logic [11:0] OFF_DST_ADDR  = 12'h104;
    localparam logic [11:0] OFF_MAT_WIDTH = 12'h108;
    localparam logic [11:0] OFF_CMD       = 12'h10C;
    localparam logic [11:0] OFF_STATUS    = 12'h110;
    localparam logic [11:0] OFF_INT_EN    = 12'h114;
    localparam logic [11:0] OFF_INT_PEND  = 12'h118;

    typedef struct packed {
        logic [29:0] reserved;
        logic        busy;
        logic        done;
    } status_t;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_VERSION,
        SEL_SRC_ADDR,
        SEL_DST_ADDR,
        SEL_MAT_WIDTH,
        SEL_CMD,
        SEL_STATUS,
        SEL_INT_EN,
        SEL_INT_PEND
    } reg_sel_e;

    // Map a word-aligned offset (byte address bits [11:2]) onto a register select.
    function automatic reg_sel_e decode_offset(input logic [9:0] word_addr);
        reg_sel_e    sel;
        logic [11:0] offset;
        offset = {word_addr, 2'b00};
        case (offset)
            OFF_VERSION:   sel = SEL_VERSION;
            OFF_SRC_ADDR:  sel = SEL_SRC_ADDR;
            OFF_DST_ADDR:  sel = SEL_DST_ADDR;
            OFF_MAT_WIDTH: sel = SEL_MAT_WIDTH;
            OFF_CMD:       sel = SEL_CMD;
            OFF_STATUS:    sel = SEL_STATUS;
            OFF_INT_EN:    sel = SEL_INT_EN;
            OFF_INT_PEND:  sel = SEL_INT_PEND;
            default:       sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mpdmac_cfg.sv
// APB register block that programs and launches the mirror-padding DMA engine.
// Holds the job configuration, issues a one-cycle start pulse, tracks busy/done
// and raises a maskable level interrupt on completion.
module mpdmac_cfg
    import mpdmac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [11:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [5:0]  mat_width_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        irq_o
);

    // Configuration and control state
    logic [31:0] src_addr_q;
    logic [31:0] dst_addr_q;
    logic [5:0]  mat_width_q;
    logic        start_q;
    logic        busy_q;
    logic        done_q;
    logic        int_en_q;
    logic        int_pend_q;
    logic        irq_q;
    logic [31:0] prdata_q;

    // Bus decode and per-access strobes
    reg_sel_e    sel;
    logic        setup_phase;
    logic        access_phase;
    logic        wr_access;
    logic        width_ok;
    logic        done_rise;
    logic        job_done;
    logic        wr_err;
    logic        wr_src;
    logic        wr_dst;
    logic        wr_width;
    logic        wr_int_en;
    logic        clr_pend;
    logic        launch;
    logic [31:0] rdata;
    status_t     status;

    // Byte-lane bits of the address carry no meaning for word registers.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^paddr_i[1:0];

    assign sel          = decode_offset(paddr_i[11:2]);
    assign setup_phase  = psel_i & ~penable_i;
    assign access_phase = psel_i & penable_i;
    assign wr_access    = access_phase & pwrite_i;
    assign width_ok     = (mat_width_q >= MIN_WIDTH) && (mat_width_q <= MAX_WIDTH);

    // done_q resets to 1 so an engine that is already idle out of reset is not
    // mistaken for a completion edge.
    assign done_rise = done_i & ~done_q;
    assign job_done  = busy_q & done_rise;

    // Classify the current write: commit strobe, launch, or error.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that left one
        // unassigned would infer a latch.
        wr_err    = 1'b0;
        wr_src    = 1'b0;
        wr_dst    = 1'b0;
        wr_width  = 1'b0;
        wr_int_en = 1'b0;
        clr_pend  = 1'b0;
        launch    = 1'b0;
        if (wr_access) begin
            case (sel)
                SEL_SRC_ADDR: begin
                    if (busy_q) wr_err = 1'b1;
                    else        wr_src = 1'b1;
                end
                SEL_DST_ADDR: begin
                    if (busy_q) wr_err = 1'b1;
                    else        wr_dst = 1'b1;
                end
                SEL_MAT_WIDTH: begin
                    if (busy_q) wr_err   = 1'b1;
                    else        wr_width = 1'b1;
                end
                SEL_CMD: begin
                    // bit0 = 0 is a legal no-op; a start must find the engine idle
                    // and a width the engine can mirror.
                    if (pwdata_i[0]) begin
                        if (busy_q || !done_i || !width_ok) wr_err = 1'b1;
                        else                                launch = 1'b1;
                    end
                end
                SEL_INT_EN:   wr_int_en = 1'b1;
                SEL_INT_PEND: clr_pend  = pwdata_i[0];
                SEL_NONE:     wr_err    = 1'b1;
                default:      ;  // read-only registers silently ignore writes
            endcase
        end
    end

    // Read data multiplexer; unmapped offsets return zero.
    always_comb begin
        status          = '0;
        status.busy     = busy_q;
        status.done     = done_i;
        rdata           = '0;
        case (sel)
            SEL_VERSION:   rdata = VERSION;
            SEL_SRC_ADDR:  rdata = src_addr_q;
            SEL_DST_ADDR:  rdata = dst_addr_q;
            SEL_MAT_WIDTH: rdata = {26'd0, mat_width_q};
            SEL_STATUS:    rdata = status;
            SEL_INT_EN:    rdata = {31'd0, int_en_q};
            SEL_INT_PEND:  rdata = {31'd0, int_pend_q};
            default:       rdata = '0;  // CMD reads zero, unmapped reads zero
        endcase
    end

    // Error response is combinational so it tracks the access phase exactly.
    assign pslverr_o = access_phase & ((sel == SEL_NONE) | wr_err);

    // Job configuration registers; frozen while a job is running.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the values from before the edge, independent of statement order.
        if (!rst_n) begin
            src_addr_q  <= '0;
            dst_addr_q  <= '0;
            mat_width_q <= '0;
        end else begin
            if (wr_src)   src_addr_q  <= pwdata_i;
            if (wr_dst)   dst_addr_q  <= pwdata_i;
            if (wr_width) mat_width_q <= pwdata_i[5:0];
        end
    end

    // Launch pulse, busy tracking, completion edge detect and interrupt state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            int_en_q   <= 1'b0;
            int_pend_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            start_q <= launch;
            done_q  <= done_i;

            if (launch)        busy_q <= 1'b1;
            else if (job_done) busy_q <= 1'b0;

            if (wr_int_en) int_en_q <= pwdata_i[0];

            // A completion landing together with a W1C keeps the pending flag set.
            if (job_done)      int_pend_q <= 1'b1;
            else if (clr_pend) int_pend_q <= 1'b0;

            irq_q <= int_pend_q & int_en_q;
        end
    end

    // Read data is captured in the setup phase and held through the access phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata_q <= '0;
        end else if (setup_phase && !pwrite_i) begin
            prdata_q <= rdata;
        end
    end

    assign pready_o    = 1'b1;
    assign prdata_o    = prdata_q;
    assign src_addr_o  = src_addr_q;
    assign dst_addr_o  = dst_addr_q;
    assign mat_width_o = mat_width_q;
    assign start_o     = start_q;
    assign irq_o       = irq_q;

endmodule
